// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped, one-word-per-line data cache.
package dcache_pkg;

   localparam int unsigned LINES   = 8;
   localparam int unsigned INDEX_W = 3;
   localparam int unsigned TAG_W   = 30 - INDEX_W;

   typedef enum logic [2:0] {
      IDLE,
      RD_MISS,
      WR_THRU,
      RESP,
      FLUSH
   } dcache_state_e;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [31:0]      data;
   } dcache_line_t;

endpackage

// File: rtl/dcache_array.sv
// Line storage: combinational read, one write port, single-cycle invalidate of all valid bits.
module dcache_array
   import dcache_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [INDEX_W-1:0] idx_i,
   output dcache_line_t       rd_line_o,
   input  logic               we_i,
   input  dcache_line_t       wr_line_i,
   input  logic               inv_all_i
);

   logic [LINES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [LINES];

   always_comb begin
      valid_d = valid_q;
      if (inv_all_i) begin
         valid_d = '0;
      end else if (we_i) begin
         valid_d[idx_i] = wr_line_i.valid;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and data are qualified by valid, so they carry no reset.
   always_ff @(posedge clk_i) begin
      if (we_i && !inv_all_i) begin
         tag_q[idx_i]  <= wr_line_i.tag;
         data_q[idx_i] <= wr_line_i.data;
      end
   end

   assign rd_line_o = '{valid: valid_q[idx_i], tag: tag_q[idx_i], data: data_q[idx_i]};

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: hit compare, miss refill, write-through stores, flush.
module dcache_ctrl
   import dcache_pkg::*;
#(
   // Reset value of the hit counter; non-zero only to exercise wrap-around.
   parameter logic [31:0] HIT_CNT_INIT = '0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cpu_req_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_wdata_i,
   output logic [31:0] cpu_rdata_o,
   output logic        cpu_stall_o,
   input  logic        flush_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_ack_i,
   output logic [31:0] hit_cnt_o,
   output logic [31:0] miss_cnt_o
);

   dcache_state_e state_q, state_d;
   logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d, flush_pend_q, flush_pend_d;
   logic [31:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, fill_q, fill_d;
   logic [31:0]   hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   cmp_tag;
   dcache_line_t       rd_line, wr_line;
   logic               line_hit, flush_take, load_hit, arr_we, inv_all;
   logic               unused_addr_bits;

   assign unused_addr_bits = ^cpu_addr_i[1:0];

   // Outside IDLE the array is addressed by the latched request.
   always_comb begin
      idx     = cpu_addr_i[INDEX_W+1:2];
      cmp_tag = cpu_addr_i[31:INDEX_W+2];
      if (state_q != IDLE) begin
         idx     = mem_addr_q[INDEX_W+1:2];
         cmp_tag = mem_addr_q[31:INDEX_W+2];
      end
   end

   assign line_hit   = rd_line.valid && (rd_line.tag == cmp_tag);
   assign flush_take = flush_i || flush_pend_q;
   assign load_hit   = (state_q == IDLE) && cpu_req_i && !cpu_we_i && !flush_take && line_hit;

   dcache_array u_array (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .idx_i     (idx),
      .rd_line_o (rd_line),
      .we_i      (arr_we),
      .wr_line_i (wr_line),
      .inv_all_i (inv_all)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         fill_q       <= '0;
         flush_pend_q <= 1'b0;
         hit_cnt_q    <= HIT_CNT_INIT;
         miss_cnt_q   <= '0;
      end else begin
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         fill_q       <= fill_d;
         flush_pend_q <= flush_pend_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      fill_d       = fill_q;
      flush_pend_d = flush_pend_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (flush_take) begin
               state_d      = FLUSH;
               flush_pend_d = 1'b0;
            end else if (cpu_req_i) begin
               if (cpu_we_i) begin
                  state_d     = WR_THRU;
                  mem_req_d   = 1'b1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = {cpu_addr_i[31:2], 2'b00};
                  mem_wdata_d = cpu_wdata_i;
               end else if (line_hit) begin
                  hit_cnt_d = hit_cnt_q + 32'd1;
               end else begin
                  state_d    = RD_MISS;
                  miss_cnt_d = miss_cnt_q + 32'd1;
                  mem_req_d  = 1'b1;
                  mem_we_d   = 1'b0;
                  mem_addr_d = {cpu_addr_i[31:2], 2'b00};
               end
            end
         end
         RD_MISS, WR_THRU: begin
            flush_pend_d = flush_pend_q || flush_i;
            if (mem_ack_i) begin
               state_d   = RESP;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (state_q == RD_MISS) begin
                  fill_d = mem_rdata_i;
               end
            end
         end
         RESP: begin
            flush_pend_d = flush_pend_q || flush_i;
            state_d      = IDLE;
         end
         FLUSH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      cpu_stall_o = 1'b0;
      cpu_rdata_o = '0;
      arr_we      = 1'b0;
      wr_line     = '{valid: 1'b1, tag: cmp_tag, data: mem_rdata_i};
      inv_all     = 1'b0;
      unique case (state_q)
         IDLE: begin
            cpu_stall_o = cpu_req_i && !load_hit;
            if (load_hit) begin
               cpu_rdata_o = rd_line.data;
            end
         end
         RD_MISS: begin
            cpu_stall_o = 1'b1;
            arr_we      = mem_ack_i;
         end
         WR_THRU: begin
            cpu_stall_o  = 1'b1;
            arr_we       = mem_ack_i && line_hit;
            wr_line.data = mem_wdata_q;
         end
         RESP: begin
            cpu_rdata_o = fill_q;
         end
         FLUSH: begin
            cpu_stall_o = cpu_req_i;
            inv_all     = 1'b1;
         end
         default: begin
            cpu_stall_o = 1'b0;
         end
      endcase
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign hit_cnt_o   = hit_cnt_q;
   assign miss_cnt_o  = miss_cnt_q;

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Controller for the 8-line, direct-mapped, one-word-per-line data cache in the MEM stage. Splits each CPU address into tag/index, holds the valid/tag/data array, answers read hits with zero wait states, and sequences read-miss refills and write-through stores over a single-outstanding req/ack memory port. It drives the pipeline stall and counts hits and misses.

## Interface
- LINES, 8: number of cache lines; power of two.
- INDEX_W, 3: log2(LINES); index = addr[INDEX_W+1:2].
- TAG_W, 27: 30-INDEX_W; tag = addr[31:INDEX_W+2].

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- cpu_req_i  in  1  load/store request valid; held stable while cpu_stall_o=1.
- cpu_we_i  in  1  1=store, 0=load.
- cpu_addr_i  in  32  byte address; bits [1:0] ignored.
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data, valid when cpu_req_i=1, cpu_we_i=0, cpu_stall_o=0.
- cpu_stall_o  out  1  freeze pipeline; request not complete this cycle.
- flush_i  in  1  invalidate all lines.
- mem_req_o  out  1  memory request, held until mem_ack_i.
- mem_we_o  out  1  memory write.
- mem_addr_o  out  32  word address ({addr[31:2],2'b00}).
- mem_wdata_o  out  32  memory write data.
- mem_rdata_i  in  32  read data, valid with mem_ack_i.
- mem_ack_i  in  1  one-cycle completion pulse.
- hit_cnt_o  out  32  load hits since reset, wraps at 2^32.
- miss_cnt_o  out  32  load misses since reset, wraps.

## Operation
- States: IDLE, RD_MISS, WR_THRU, RESP, FLUSH.
- IDLE, flush_i=1: -> FLUSH; cpu_stall_o=1 if cpu_req_i=1. Flush beats a same-cycle request.
- IDLE, load hit (valid[idx] && tag[idx]==tag): cpu_rdata_o=data[idx] combinationally, stall=0, hit_cnt+1, stay IDLE.
- IDLE, load miss: stall=1, latch addr, miss_cnt+1, -> RD_MISS.
- IDLE, store (hit or miss): stall=1, latch addr/wdata, -> WR_THRU.
- RD_MISS: mem_req_o=1, mem_we_o=0, mem_addr_o=latched. On mem_ack_i: line[idx] <= {valid=1, tag, mem_rdata_i}; fill register <= mem_rdata_i; -> RESP.
- WR_THRU: mem_req_o=1, mem_we_o=1, mem_wdata_o=latched wdata. On mem_ack_i: if latched line hits, data[idx] <= wdata (write-through, no-write-allocate; miss leaves array unchanged); -> RESP.
- RESP: stall=0, cpu_rdata_o=fill register (loads); -> IDLE. flush_i seen in RESP is held pending and taken from IDLE next cycle.
- FLUSH: all valid bits <= 0 on this edge; stall=1 if cpu_req_i; -> IDLE.
- flush_i arriving in RD_MISS/WR_THRU: registered as pending, serviced on return to IDLE, before any new request.
- Store to a line then load same address: load hits with new data.
- Index conflict: refill overwrites line unconditionally (no dirty data exists).

## Timing
- Reset values: state=IDLE, all valid=0, cpu_stall_o=0 (unless cpu_req_i, combinational), cpu_rdata_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, hit_cnt_o=0, miss_cnt_o=0, flush pending=0. Tag/data arrays need not reset.
- Load hit: 0 stall cycles.
- Load miss: stall cycles = 1 (IDLE) + N (cycles in RD_MISS up to and including ack cycle); data in RESP. With ack on first RD_MISS cycle: 2 stall cycles, data cycle 3.
- Store: same latency as load miss.
- mem_req_o and mem_* outputs registered, stable from entry to RD_MISS/WR_THRU until ack cycle inclusive; drop the cycle after ack.
- mem_ack_i in IDLE/RESP/FLUSH: ignored.
- Reset mid-transaction: immediate return to IDLE, mem_req_o=0, array invalidated; late ack ignored; counters cleared.

## Structure
- Package dcache_pkg: state enum (dcache_state_e), LINES/INDEX_W/TAG_W constants, line struct {valid, tag, data}.
- Sub-module dcache_array: LINES x line storage, combinational read by index, one write port, single-cycle invalidate-all, async clear of valid bits.
- dcache_ctrl: FSM, request latch, flush pending, counters, hit compare.

## Test plan
- Reset, load 0x0000_0040 -> miss, stall 2 cycles with ack after 1, mem_addr_o=0x40, rdata=ack data 0xDEAD_BEEF in RESP; reload -> 0-stall hit, same data, hit_cnt=1, miss_cnt=1.
- Load 0x40 then 0x60 (same index 0, different tag) -> both miss, third load 0x40 misses again; miss_cnt=3.
- Store 0x1234_5678 to cached 0x40 -> mem_we_o=1, mem_wdata_o=0x1234_5678 held until ack (delay 5 cycles); subsequent load 0x40 hits 0x1234_5678. Store to uncached 0x80 -> load 0x80 misses.
- flush_i and cpu_req_i same IDLE cycle -> 1-cycle FLUSH stall, then previously cached 0x40 misses; flush_i mid-RD_MISS -> refill completes, flush taken after RESP.
- rst_ni low during RD_MISS -> mem_req_o=0 immediately, counters 0; ack pulse after release ignored, state stays IDLE.
- hit_cnt_o forced near 0xFFFF_FFFF via 2 hits from preload -> wraps to 0x0000_0000.
